alu_result_fifo: RTL and testbench

- Downstream buffer for the combinational 32-bit ALU. Captures each ALU result with its carryout, zero and overflow flags and a 3-bit command tag.
- Queues captured entries in a small synchronous FIFO and hands them to the writeback/consumer through a valid/ready handshake.
- Keeps an occupancy count and a sticky arithmetic-overflow status bit. These let the next stage be stalled without re-running the ALU.

---
 rtl/alu_result_fifo_pkg.sv | 26 ++
 rtl/alu_result_fifo_if.sv | 40 ++++
 rtl/alu_result_fifo_mem.sv | 27 ++
 rtl/alu_result_fifo.sv | 98 +++++++++
 tb/tb_alu_result_fifo.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/alu_result_fifo_pkg.sv
// Shared definitions for the ALU result FIFO: command encoding, entry
// layout and a small helper used by the sticky-overflow logic.
// Optional feature macro: ALU_RESULT_FIFO_BYPASS_EN (see alu_result_fifo.sv).
package alu_result_fifo_pkg;

  typedef enum logic [2:0] {
    CMD_ADD = 3'd0,
    CMD_SUB = 3'd1,
    CMD_XOR = 3'd2,
    CMD_SLT = 3'd3,
    CMD_CNE = 3'd4
  } alu_cmd_e;

  localparam int ENTRY_W    = 38;
  localparam int RESULT_LSB = 0;
  localparam int CARRY_BIT  = 32;
  localparam int ZERO_BIT   = 33;
  localparam int OVF_BIT    = 34;
  localparam int CMD_LSB    = 35;

  // Only ADD and SUB produce a meaningful overflow flag.
  function automatic logic is_arith(input logic [2:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

endpackage

// File: rtl/alu_result_fifo_if.sv
// Producer/consumer bundle for the ALU result FIFO. The FIFO uses the
// slave modport; whoever drives the ALU side and consumes results uses master.
// DEPTH must match the DEPTH of the attached alu_result_fifo.
interface alu_result_fifo_if #(parameter int DEPTH = 4);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic             in_carryout;
  logic             in_zero;
  logic             in_overflow;
  logic [2:0]       in_command;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_carryout;
  logic             out_zero;
  logic             out_overflow;
  logic [2:0]       out_command;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             ovf_sticky;
  logic             sticky_clr;

  modport master (
    output in_valid, in_result, in_carryout, in_zero, in_overflow, in_command,
    output out_ready, flush, sticky_clr,
    input  in_ready, out_valid, out_result, out_carryout, out_zero,
    input  out_overflow, out_command, count, ovf_sticky
  );

  modport slave (
    input  in_valid, in_result, in_carryout, in_zero, in_overflow, in_command,
    input  out_ready, flush, sticky_clr,
    output in_ready, out_valid, out_result, out_carryout, out_zero,
    output out_overflow, out_command, count, ovf_sticky
  );

endinterface

// File: rtl/alu_result_fifo_mem.sv
// Entry storage for the ALU result FIFO: synchronous write, asynchronous
// read by pointer. No reset; stale contents are masked by the occupancy count.
module fifo_mem
  import alu_result_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = ENTRY_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed slot on an accepted push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: buffers {command, overflow, zero, carryout, result}
// entries between the ALU and writeback, with occupancy count and a sticky
// ADD/SUB overflow bit.
// Optional macro ALU_RESULT_FIFO_BYPASS_EN: first-word fall-through when
// empty; otherwise every entry takes one cycle to reach the outputs.
module alu_result_fifo
  import alu_result_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  alu_result_fifo_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_q;
  logic [ENTRY_W-1:0] wr_entry, rd_entry, head;
  logic               stored_valid, bypass_live, bypass_take;
  logic               push, pop, wr_en, rd_en;

  assign wr_entry = {bus.in_command, bus.in_overflow, bus.in_zero,
                     bus.in_carryout, bus.in_result};

  assign stored_valid = (count_q != '0);
  assign bus.in_ready = (count_q != CNT_W'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready;

`ifdef ALU_RESULT_FIFO_BYPASS_EN
  assign bypass_live = ~stored_valid & bus.in_valid & ~bus.flush;
`else
  assign bypass_live = 1'b0;
`endif

  assign bus.out_valid = stored_valid | bypass_live;
  assign pop           = bus.out_valid & bus.out_ready;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign bypass_take   = bypass_live & bus.out_ready;
  assign wr_en         = push & ~bus.flush & ~bypass_take & ~reset;
  assign rd_en         = pop  & ~bus.flush & ~bypass_take;

  fifo_mem #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Head selection: stored entry, bypassed input, or zeros when empty.
  always_comb begin
    head = '0;
    if (stored_valid)     head = rd_entry;
    else if (bypass_live) head = wr_entry;
  end

  assign bus.out_result   = head[RESULT_LSB +: 32];
  assign bus.out_carryout = head[CARRY_BIT];
  assign bus.out_zero     = head[ZERO_BIT];
  assign bus.out_overflow = head[OVF_BIT];
  assign bus.out_command  = head[CMD_LSB +: 3];
  assign bus.count        = count_q;
  assign bus.ovf_sticky   = ovf_q;

  // Pointers and occupancy; flush empties the queue and drops same-cycle traffic.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow: an accepted ADD/SUB overflow wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (push && !bus.flush && bus.in_overflow && is_arith(bus.in_command)) begin
      ovf_q <= 1'b1;
    end else if (bus.sticky_clr) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;
  import alu_result_fifo_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [ENTRY_W-1:0] sb[$];
  bit   m_sticky = 1'b0;

  always #5 clk = ~clk;

  alu_result_fifo_if #(.DEPTH(DEPTH)) bus ();
  alu_result_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [ENTRY_W-1:0] mk(input logic [2:0] cmd, input bit ovf,
                                            input bit zero, input bit carry,
                                            input logic [31:0] res);
    return {cmd, ovf, zero, carry, res};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check current outputs against the model, advance model.
  task automatic cyc(input bit rst, input bit vin, input logic [ENTRY_W-1:0] e,
                     input bit rdy, input bit fl, input bit clr);
    int n;
    bit byp, exp_ov, acc_push, acc_pop;
    logic [ENTRY_W-1:0] exp_head;
    @(negedge clk);
    reset           = rst;
    bus.in_valid    = vin;
    bus.in_result   = e[RESULT_LSB +: 32];
    bus.in_carryout = e[CARRY_BIT];
    bus.in_zero     = e[ZERO_BIT];
    bus.in_overflow = e[OVF_BIT];
    bus.in_command  = e[CMD_LSB +: 3];
    bus.out_ready   = rdy;
    bus.flush       = fl;
    bus.sticky_clr  = clr;
    #1;
    n   = sb.size();
    byp = 1'b0;
`ifdef ALU_RESULT_FIFO_BYPASS_EN
    byp = (n == 0) && vin && !fl;
`endif
    exp_ov   = (n != 0) || byp;
    exp_head = (n != 0) ? sb[0] : (byp ? e : '0);
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    chk("in_ready", 64'(bus.in_ready), 64'(n != DEPTH));
    chk("count", 64'(bus.count), 64'(n));
    chk("ovf_sticky", 64'(bus.ovf_sticky), 64'(m_sticky));
    chk("head", 64'({bus.out_command, bus.out_overflow, bus.out_zero,
                     bus.out_carryout, bus.out_result}), 64'(exp_head));
    acc_push = vin && (n != DEPTH) && !fl;
    acc_pop  = exp_ov && rdy && !fl;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_sticky = 1'b0;
    end else begin
      if (fl) sb.delete();
      else begin
        if (acc_pop && n != 0) void'(sb.pop_front());
        if (acc_push && !(byp && rdy)) sb.push_back(e);
      end
      if (acc_push && e[OVF_BIT] && is_arith(e[CMD_LSB +: 3])) m_sticky = 1'b1;
      else if (clr) m_sticky = 1'b0;
    end
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, '0, rdy, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 0; bus.in_result = '0; bus.in_carryout = 0; bus.in_zero = 0;
    bus.in_overflow = 0; bus.in_command = '0; bus.out_ready = 0;
    bus.flush = 0; bus.sticky_clr = 0;
    repeat (2) @(posedge clk);

    // Reset state, single push, hold
    idle(0);
    cyc(0, 1, mk(CMD_ADD, 0, 0, 0, 32'h5), 0, 0, 0);
    repeat (3) idle(0);
    idle(1);
    idle(0);

    // Fill to full, rejected offer, pop at full with offer, drain
    for (int i = 0; i < 4; i++)
      cyc(0, 1, mk(3'(i % 5), 0, i[0], i[1], 32'h10 + i), 0, 0, 0);
    cyc(0, 1, mk(CMD_ADD, 0, 0, 0, 32'h14), 0, 0, 0);
    cyc(0, 1, mk(CMD_ADD, 0, 0, 0, 32'h14), 1, 0, 0);
    repeat (4) idle(1);
    idle(0);

    // Steady state at count=2 with simultaneous push/pop across pointer wrap
    cyc(0, 1, mk(CMD_XOR, 0, 0, 0, 32'h100), 0, 0, 0);
    cyc(0, 1, mk(CMD_XOR, 0, 1, 0, 32'h101), 0, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc(0, 1, mk(CMD_SLT, 0, 0, 0, 32'h200 + i), 1, 0, 0);
    repeat (3) idle(1);

    // Sticky overflow: set, clear, non-arith ignored, set beats clear
    cyc(0, 1, mk(CMD_SUB, 1, 0, 1, 32'h8000_0000), 1, 0, 0);
    idle(1);
    cyc(0, 0, '0, 1, 0, 1);
    cyc(0, 1, mk(CMD_XOR, 1, 0, 0, 32'h1), 1, 0, 0);
    idle(1);
    cyc(0, 1, mk(CMD_ADD, 1, 0, 0, 32'h7FFF_FFFF), 1, 0, 1);
    idle(1);
    idle(1);

    // Flush with simultaneous push, then reset mid-operation
    for (int i = 0; i < 3; i++)
      cyc(0, 1, mk(CMD_CNE, 0, 0, 0, 32'h300 + i), 0, 0, 0);
    cyc(0, 1, mk(CMD_ADD, 0, 0, 0, 32'hAA), 1, 1, 0);
    idle(0);
    cyc(0, 1, mk(CMD_ADD, 0, 0, 0, 32'h400), 0, 0, 0);
    cyc(0, 1, mk(CMD_ADD, 0, 0, 0, 32'h401), 0, 0, 0);
    cyc(1, 0, '0, 0, 0, 0);
    idle(0);

    // Empty FIFO with a consumer ready: bypass vs registered latency
    cyc(0, 1, mk(CMD_ADD, 0, 0, 1, 32'hDEAD_BEEF), 1, 0, 0);
    idle(1);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
